fc_layer_mem: RTL and testbench
===============================

# fc_layer_mem

Memory responder for one fully connected layer engine. It holds the layer's input activations and weights, serves the engine's address-driven reads with a registered one-cycle latency, and captures the engine's output writes into a dedicated output region. It also runs the start/enable/layer-end handshake toward the engine. A host port loads the memory beforehand and reads results back afterwards. It sits between the system controller and one FC layer engine.

## Interface
- `DEPTH`, 64: words of 16-bit storage.
- `AW`, 6: address bits used internally; `DEPTH` = 2^`AW`.
- `BCK_CELL`, 5: expected number of engine output writes per run.
- `OUT_BASE`, 48: first word of the output region.
- `TIMEOUT`, 1023: maximum cycles allowed in RUN before the run is aborted.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to run the layer; honoured only in IDLE.
- `host_we`  in  1  host write strobe.
- `host_addr`  in  AW  host word address.
- `host_wdata`  in  16  host write data.
- `host_rdata`  out  16  registered host read data: mem[`host_addr`] from the previous cycle.
- `lyr_enable`  out  1  enable to the engine.
- `lyr_addr`  in  16  engine read/write address; only bits [AW-1:0] are used for reads.
- `lyr_we`  in  1  engine write strobe.
- `lyr_wdata`  in  16  engine output data.
- `lyr_end`  in  1  engine layer-end flag.
- `lyr_rdata`  out  16  registered read data returned to the engine.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse at run completion.
- `cnt_err`  out  1  sticky: write count at `lyr_end` was not equal to `BCK_CELL`.
- `ovf_err`  out  1  sticky: an engine write arrived after `BCK_CELL` writes.
- `host_err`  out  1  sticky: `host_we` was asserted while `busy`.
- `timeout_err`  out  1  sticky: the run was aborted by the watchdog.

## Operation
- States: IDLE, RUN, DONE.
- IDLE to RUN: when `start` is high. On entry, `wr_cnt` and the watchdog counter clear, all sticky errors clear, and `lyr_enable` rises on the next cycle.
- RUN to DONE: when `lyr_end` is high. In the same cycle, `cnt_err` is set if `wr_cnt` is not equal to `BCK_CELL`.
- RUN to IDLE (abort): when the watchdog counter reaches `TIMEOUT`. This sets `timeout_err`. `done` is not pulsed.
- DONE to IDLE: unconditionally after one cycle. `done` is high during the DONE cycle.
- `lyr_enable` is high exactly while the state is RUN.
- `lyr_end` is ignored outside RUN; the engine holds it high after finishing.
- Engine reads:
  - In every cycle, `lyr_rdata` <= mem[`lyr_addr`[AW-1:0]], regardless of state.
  - Address wrap modulo `DEPTH` is intended.
- Engine writes:
  - Accepted only in RUN with `lyr_we` high.
  - The write address is `OUT_BASE` + `wr_cnt`, taken modulo `DEPTH`. `lyr_addr` is ignored for writes.
  - `wr_cnt` increments on each accepted write.
  - A write with `wr_cnt` equal to `BCK_CELL` is dropped and sets `ovf_err`; `wr_cnt` saturates.
- Host writes:
  - Performed only when not `busy`.
  - When `busy`, the write is dropped and `host_err` is set.
- Host reads are always allowed: `host_rdata` <= mem[`host_addr`] every cycle.
- Same-address read and write in one cycle: the read returns the old data. Memory is write-first only on the following cycle.
- Engine write and host write in the same cycle cannot both land, because host writes are dropped while `busy`.
- Memory contents are not cleared by reset.

## Timing
- Reset values: state IDLE, `lyr_enable`=0, `busy`=0, `done`=0, all error flags 0, `lyr_rdata`=0, `host_rdata`=0, `wr_cnt`=0, watchdog counter 0.
- Reset asserted mid-run returns the block to IDLE immediately, with `lyr_enable`=0. The partially written output region stays as written.
- `start` at edge k gives `lyr_enable`=1 from edge k+1.
- `lyr_end` seen at edge m gives `lyr_enable`=0 and `done`=1 from edge m+1, and `done`=0 from edge m+2.
- Read latency is 1 cycle for both ports.
- A write lands at the edge where `lyr_we` or `host_we` is sampled and is visible on a read issued after that edge.
- `start` while `busy` is ignored, with no error.
- Watchdog: counts every RUN cycle. At count `TIMEOUT` the state goes to IDLE on the next edge.

## Test plan
- Load and readback: host writes 0x0100 to addr 0 and 0xFF00 to addr 10. Reading addr 0 returns 0x0100 one cycle later; reading addr 10 returns 0xFF00.
- Full run: the engine model with FRT=10 and BCK=5 reads inputs and weights and issues 5 writes of 0x0001..0x0005, then raises `lyr_end`. Required: mem[48..52] = 1..5, a single `done` pulse, `cnt_err`=0, and `lyr_enable` low afterwards.
- Count errors:
  - A run with only 4 writes sets `cnt_err`=1.
  - A run with 6 writes sets `ovf_err`=1, leaves mem[53] unchanged, and mem[48..52] holds the first 5 values.
- Host collision: `host_we` to addr 3 during RUN sets `host_err`=1 and leaves mem[3] unchanged. A subsequent `start` clears `host_err`.
- Timeout and reset:
  - An engine that never raises `lyr_end` sees `lyr_enable` drop after `TIMEOUT`+1 RUN cycles, with `timeout_err`=1 and no `done`.
  - A separate run with `reset_n` pulsed mid-run ends with all outputs at their reset values, and the next `start` runs normally.
- Wrap and same-cycle read/write: `lyr_addr`=0x0041 reads mem[1]. An engine read of addr 48 in the same cycle as the write to 48 returns the old value, and returns the new value on the next read.

Source files
------------

// File: rtl/fc_layer_mem.sv
// rtl/fc_layer_mem.sv - FC layer engine memory responder with run handshake
// Holds activations/weights, serves engine reads, captures outputs into OUT_BASE region.
module fc_layer_mem #(
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int BCK_CELL = 5,
  parameter int OUT_BASE = 48,
  parameter int TIMEOUT  = 1023
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [15:0]   host_wdata,
  output logic [15:0]   host_rdata,
  output logic          lyr_enable,
  input  logic [15:0]   lyr_addr,
  input  logic          lyr_we,
  input  logic [15:0]   lyr_wdata,
  input  logic          lyr_end,
  output logic [15:0]   lyr_rdata,
  output logic          busy,
  output logic          done,
  output logic          cnt_err,
  output logic          ovf_err,
  output logic          host_err,
  output logic          timeout_err
);

  localparam int CW = $clog2(BCK_CELL + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] wr_cnt;
  logic [WW-1:0] wd_cnt;
  logic [15:0]   mem [DEPTH];

  logic          in_run;
  logic          eng_we;
  logic          eng_ok;
  logic          host_ok;
  logic          cnt_full;
  logic [AW-1:0] out_addr;
  logic          unused_addr_bits;

  assign in_run     = (state == S_RUN);
  assign busy       = (state == S_RUN) || (state == S_DONE);
  assign done       = (state == S_DONE);
  assign lyr_enable = in_run;

  assign cnt_full = (wr_cnt == CW'(BCK_CELL));
  assign eng_we   = in_run && lyr_we;
  assign eng_ok   = eng_we && !cnt_full;
  assign host_ok  = host_we && !busy;
  assign out_addr = AW'(OUT_BASE) + AW'(wr_cnt);

  // Engine addresses wrap modulo DEPTH; upper bits are deliberately dropped.
  assign unused_addr_bits = ^lyr_addr[15:AW];

  // Storage has no reset so loaded contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (eng_ok) begin
      mem[out_addr] <= lyr_wdata;
    end else if (host_ok) begin
      mem[host_addr] <= host_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lyr_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      lyr_rdata  <= mem[lyr_addr[AW-1:0]];
      host_rdata <= mem[host_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wr_cnt      <= '0;
      wd_cnt      <= '0;
      cnt_err     <= 1'b0;
      ovf_err     <= 1'b0;
      host_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RUN;
            wr_cnt      <= '0;
            wd_cnt      <= '0;
            cnt_err     <= 1'b0;
            ovf_err     <= 1'b0;
            host_err    <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        S_RUN: begin
          if (eng_we) begin
            if (eng_ok) begin
              wr_cnt <= wr_cnt + CW'(1);
            end else begin
              ovf_err <= 1'b1;
            end
          end
          if (host_we) begin
            host_err <= 1'b1;
          end
          // A layer end wins over a watchdog expiry in the same cycle.
          if (lyr_end) begin
            state   <= S_DONE;
            cnt_err <= !cnt_full;
          end else if (wd_cnt == WW'(TIMEOUT)) begin
            state       <= S_IDLE;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (host_we) begin
            host_err <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_mem.sv
// tb/tb_fc_layer_mem.sv - directed self-checking bench for fc_layer_mem
// Host and engine stimulus are driven 1ns after each rising edge.
module tb_fc_layer_mem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        host_we;
  logic [5:0]  host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        lyr_enable;
  logic [15:0] lyr_addr;
  logic        lyr_we;
  logic [15:0] lyr_wdata;
  logic        lyr_end;
  logic [15:0] lyr_rdata;
  logic        busy;
  logic        done;
  logic        cnt_err;
  logic        ovf_err;
  logic        host_err;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  logic [15:0] rd_first;
  logic [15:0] rd_second;
  int          run_cnt;
  logic        seen_done;

  fc_layer_mem dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .lyr_enable  (lyr_enable),
    .lyr_addr    (lyr_addr),
    .lyr_we      (lyr_we),
    .lyr_wdata   (lyr_wdata),
    .lyr_end     (lyr_end),
    .lyr_rdata   (lyr_rdata),
    .busy        (busy),
    .done        (done),
    .cnt_err     (cnt_err),
    .ovf_err     (ovf_err),
    .host_err    (host_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [5:0] a, input logic [15:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [5:0] a, input logic [15:0] exp);
    host_addr = a;
    tick();
    check(tag, 32'(host_rdata), 32'(exp));
  endtask

  // Engine model: n output writes of v0, v0+1, ... while reading addr 48, then layer end.
  task automatic run_layer(input int n, input logic [15:0] v0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("enable_on", 32'(lyr_enable), 32'd1);
    check("busy_on", 32'(busy), 32'd1);
    lyr_addr = 16'd48;
    for (int i = 0; i < n; i++) begin
      lyr_we    = 1'b1;
      lyr_wdata = v0 + 16'(i);
      tick();
      if (i == 0) rd_first = lyr_rdata;
      if (i == 1) rd_second = lyr_rdata;
    end
    lyr_we  = 1'b0;
    lyr_end = 1'b1;
    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("enable_off", 32'(lyr_enable), 32'd0);
    lyr_end = 1'b0;
    tick();
    check("done_clear", 32'(done), 32'd0);
    check("busy_off", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable"}, 32'(lyr_enable), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_cnt_err"}, 32'(cnt_err), 32'd0);
    check({tag, "_ovf_err"}, 32'(ovf_err), 32'd0);
    check({tag, "_host_err"}, 32'(host_err), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_lyr_rdata"}, 32'(lyr_rdata), 32'd0);
    check({tag, "_host_rdata"}, 32'(host_rdata), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    lyr_addr   = '0;
    lyr_we     = 1'b0;
    lyr_wdata  = '0;
    lyr_end    = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset_n = 1'b1;
    tick();

    host_write(6'd0, 16'h0100);
    host_write(6'd10, 16'hFF00);
    host_write(6'd1, 16'h1234);
    host_write(6'd3, 16'h0333);
    host_write(6'd48, 16'h4800);
    host_write(6'd53, 16'hDEAD);
    host_read("load_a0", 6'd0, 16'h0100);
    host_read("load_a10", 6'd10, 16'hFF00);

    lyr_addr = 16'h0041;
    tick();
    check("wrap_read", 32'(lyr_rdata), 32'h1234);

    run_layer(5, 16'h0001);
    check("full_cnt_err", 32'(cnt_err), 32'd0);
    check("full_ovf_err", 32'(ovf_err), 32'd0);
    check("rw_same_old", 32'(rd_first), 32'h4800);
    check("rw_same_new", 32'(rd_second), 32'h0001);
    for (int i = 0; i < 5; i++) host_read("full_out", 6'(48 + i), 16'(i + 1));

    run_layer(4, 16'h0021);
    check("short_cnt_err", 32'(cnt_err), 32'd1);
    check("short_ovf_err", 32'(ovf_err), 32'd0);

    run_layer(6, 16'h0011);
    check("ovf_ovf_err", 32'(ovf_err), 32'd1);
    check("ovf_cnt_err", 32'(cnt_err), 32'd0);
    for (int i = 0; i < 5; i++) host_read("ovf_out", 6'(48 + i), 16'(16'h0011 + i));
    host_read("ovf_a53", 6'd53, 16'hDEAD);

    start = 1'b1;
    tick();
    start = 1'b0;
    host_write(6'd3, 16'hBEEF);
    check("coll_host_err", 32'(host_err), 32'd1);
    lyr_end = 1'b1;
    tick();
    check("coll_done", 32'(done), 32'd1);
    lyr_end = 1'b0;
    tick();
    host_read("coll_a3", 6'd3, 16'h0333);
    check("coll_sticky", 32'(host_err), 32'd1);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clr_host_err", 32'(host_err), 32'd0);
    run_cnt   = 0;
    seen_done = 1'b0;
    while (lyr_enable && run_cnt < 2000) begin
      run_cnt++;
      tick();
      if (done) seen_done = 1'b1;
    end
    check("to_run_cycles", 32'(run_cnt), 32'd1024);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_no_done", 32'(seen_done), 32'd0);
    check("to_busy", 32'(busy), 32'd0);

    start = 1'b1;
    tick();
    start  = 1'b0;
    lyr_we = 1'b1;
    lyr_wdata = 16'h0041;
    tick();
    lyr_wdata = 16'h0042;
    tick();
    lyr_we  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_async_enable", 32'(lyr_enable), 32'd0);
    tick();
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    tick();
    host_read("midrst_a48", 6'd48, 16'h0041);
    host_read("midrst_a49", 6'd49, 16'h0042);

    run_layer(5, 16'h0051);
    check("rerun_cnt_err", 32'(cnt_err), 32'd0);
    check("rerun_to_err", 32'(timeout_err), 32'd0);
    host_read("rerun_a52", 6'd52, 16'h0055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
